// File: rtl/tan_cordic.sv
// tan_cordic: angle (integer degrees) -> sin, cos, tan in Q1.14.
// Iterative CORDIC rotation for sin/cos, then restoring division for tan = sin/cos.
// The atan ROM and the CORDIC gain constant are scaled for FRAC+GUARD = 18;
// ITER may be at most 16.
module tan_cordic #(
  parameter int ITER  = 16,
  parameter int FRAC  = 14,
  parameter int GUARD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] angle_deg,
  output logic               busy,
  output logic               done,
  output logic signed [15:0] sin_out,
  output logic signed [15:0] cos_out,
  output logic signed [15:0] tan_out,
  output logic               sat
);
  localparam int FG = FRAC + GUARD;
  localparam int XW = FG + 6;    // x/y: headroom for the 1.647 CORDIC growth plus sign
  localparam int ZW = FG + 10;   // z: +/-90 degrees plus the ROM overshoot
  localparam int QW = 16;        // quotient bits, one per DIV cycle
  localparam int DW = XW + QW;   // remainder/divisor width
  localparam int CW = 5;
  localparam logic signed [XW-1:0] K_INIT = XW'(159188);   // 0.6072529 * 2^18
  localparam logic signed [XW-1:0] RND    = XW'(1 << (GUARD - 1));
  localparam logic signed [XW-1:0] SMAX   = XW'(32767);
  localparam logic signed [XW-1:0] SMIN   = -XW'(32768);
  localparam logic signed [15:0]   ONE    = 16'(1 << FRAC);

  typedef enum logic [1:0] {IDLE, ROT, DIV, DONE} state_t;

  state_t                state_q, state_d;
  logic signed [XW-1:0]  x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0]  z_q, z_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         rem_q, rem_d, dv_q, dv_d;
  logic [QW-1:0]         quo_q, quo_d;
  logic                  ovf_q, ovf_d;
  logic signed [15:0]    sin_q, sin_d, cos_q, cos_d, tan_q, tan_d;
  logic                  sat_q, sat_d;

  // atan(2^-i) in degrees, scaled by 2^18
  function automatic logic signed [ZW-1:0] atan_rom(input logic [3:0] i);
    case (i)
      4'd0:  return ZW'(11796480);
      4'd1:  return ZW'(6963869);
      4'd2:  return ZW'(3679517);
      4'd3:  return ZW'(1867780);
      4'd4:  return ZW'(937515);
      4'd5:  return ZW'(469214);
      4'd6:  return ZW'(234664);
      4'd7:  return ZW'(117339);
      4'd8:  return ZW'(58671);
      4'd9:  return ZW'(29335);
      4'd10: return ZW'(14668);
      4'd11: return ZW'(7334);
      4'd12: return ZW'(3667);
      4'd13: return ZW'(1833);
      4'd14: return ZW'(917);
      default: return ZW'(458);
    endcase
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [XW-1:0] v);
    if (v > SMAX)      return 16'sh7fff;
    else if (v < SMIN) return 16'sh8000;
    else               return v[15:0];
  endfunction

  logic signed [15:0]   ang_c;
  logic signed [XW-1:0] xs, ys, x_rot, y_rot, x_rnd, y_rnd;
  logic signed [ZW-1:0] z_rot;
  logic [XW-1:0]        ax, ay;
  logic                 ge, x_zero, t_sat, t_neg;
  logic [DW-1:0]        rem_n;
  logic [QW-1:0]        quo_n, t_mag;

  // next-state, datapath step and result formatting
  always_comb begin
    state_d = state_q;
    x_d = x_q; y_d = y_q; z_d = z_q; cnt_d = cnt_q;
    rem_d = rem_q; dv_d = dv_q; quo_d = quo_q; ovf_d = ovf_q;
    sin_d = sin_q; cos_d = cos_q; tan_d = tan_q; sat_d = sat_q;

    ang_c = angle_deg;
    if (angle_deg > 16'sd90)       ang_c = 16'sd90;
    else if (angle_deg < -16'sd90) ang_c = -16'sd90;

    // micro-rotation, d = +1 when z >= 0
    xs = x_q >>> cnt_q;
    ys = y_q >>> cnt_q;
    x_rot = z_q[ZW-1] ? x_q + ys : x_q - ys;
    y_rot = z_q[ZW-1] ? y_q - xs : y_q + xs;
    z_rot = z_q[ZW-1] ? z_q + atan_rom(cnt_q[3:0]) : z_q - atan_rom(cnt_q[3:0]);
    ax = x_rot[XW-1] ? -x_rot : x_rot;
    ay = y_rot[XW-1] ? -y_rot : y_rot;

    // one restoring-division step
    ge    = rem_q >= dv_q;
    rem_n = ge ? rem_q - dv_q : rem_q;
    quo_n = {quo_q[QW-2:0], ge};

    // result formatting from the final x/y and full quotient
    x_rnd  = (x_q + RND) >>> GUARD;
    y_rnd  = (y_q + RND) >>> GUARD;
    x_zero = (x_rnd == '0);
    t_sat  = x_zero || ovf_q || quo_n[QW-1];
    // a cosine that rounds to zero carries no usable sign; take it from sin alone
    t_neg  = x_zero ? y_q[XW-1] : (y_q[XW-1] ^ x_q[XW-1]);
    t_mag  = t_sat ? 16'h7fff : quo_n;

    case (state_q)
      IDLE: if (start) begin
        state_d = ROT;
        z_d     = ZW'(ang_c) <<< FG;
        x_d     = K_INIT;
        y_d     = '0;
        cnt_d   = '0;
      end
      ROT: begin
        x_d   = x_rot;
        y_d   = y_rot;
        z_d   = z_rot;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) begin
          state_d = DIV;
          cnt_d   = '0;
          rem_d   = DW'(ay) << FRAC;
          dv_d    = DW'(ax) << (QW - 1);
          quo_d   = '0;
          // quotient would need more than QW bits
          ovf_d   = (DW'(ay) << FRAC) >= (DW'(ax) << QW);
        end
      end
      DIV: begin
        rem_d = rem_n;
        dv_d  = dv_q >> 1;
        quo_d = quo_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(QW - 1)) begin
          state_d = DONE;
          sin_d   = sat16(y_rnd);
          cos_d   = sat16(x_rnd);
          tan_d   = t_neg ? 16'(-t_mag) : t_mag;
          sat_d   = t_sat;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q <= '0; y_q <= '0; z_q <= '0; cnt_q <= '0;
      rem_q <= '0; dv_q <= '0; quo_q <= '0; ovf_q <= 1'b0;
      sin_q <= '0; cos_q <= ONE; tan_q <= '0; sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d; y_q <= y_d; z_q <= z_d; cnt_q <= cnt_d;
      rem_q <= rem_d; dv_q <= dv_d; quo_q <= quo_d; ovf_q <= ovf_d;
      sin_q <= sin_d; cos_q <= cos_d; tan_q <= tan_d; sat_q <= sat_d;
    end
  end

  assign busy    = (state_q == ROT) || (state_q == DIV);
  assign done    = (state_q == DONE);
  assign sin_out = sin_q;
  assign cos_out = cos_q;
  assign tan_out = tan_q;
  assign sat     = sat_q;
endmodule
